sum_collect: RTL and testbench

SUM_COLLECT -- requirements
Module: sum_collect

---
 rtl/sum_collect_pkg.sv | 18 +
 rtl/res_fifo2.sv | 50 +++++
 rtl/sum_collect.sv | 95 +++++++++
 tb/tb_sum_collect.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sum_collect_pkg.sv
// Shared adder package: collector FSM encodings and result buffer depth,
// common to the serial adder and its result collector.
package sum_collect_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_WRITE = 2'd2;

    localparam int RES_DEPTH = 2;

    // Bit counter width; a 1-bit result still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/res_fifo2.sv
// Two-entry in-order result buffer with simultaneous push/pop support.
module res_fifo2 #(
    parameter int DW    = 9,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == 2'(DEPTH));
    assign empty   = (cnt == 2'd0);
    assign do_pop  = pop && !empty;
    // A push into a full buffer only lands when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/sum_collect.sv
// Collects LSB-first serial sum bits plus final carry into parallel results
// and queues them in a small buffer for the consumer.
module sum_collect
    import sum_collect_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = RES_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_vld,
    input  logic             bit_in,
    input  logic             carry_in,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic             busy,
    output logic             err
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    count;
    logic             carry;
    logic             last_bit;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign last_bit = (state == ST_SHIFT) && bit_vld && (count == CW'(WIDTH - 1));
    assign pop      = res_vld && res_rdy;
    assign push     = (state == ST_WRITE) && (!full || pop);
    assign res_vld  = !empty;
    assign busy     = (state != ST_IDLE);
    assign err      = start && (state != ST_IDLE) && !rst;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)    state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_nxt = ST_WRITE;
            ST_WRITE: if (push)     state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            count <= '0;
            carry <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg <= '0;
                        count <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (bit_vld) begin
                        shreg <= {bit_in, shreg[WIDTH-1:1]};
                        // Counter parks at WIDTH-1 on the last bit instead of wrapping.
                        if (last_bit) carry <= carry_in;
                        else          count <= count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    res_fifo2 #(
        .DW    (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({carry, shreg}),
        .dout  ({res_carry, res_data}),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_sum_collect.sv
// Directed bench for sum_collect; a scoreboard queue holds expected results
// and a monitor compares every accepted buffer head against it.
module tb_sum_collect;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bit_vld = 1'b0;
    logic       bit_in = 1'b0;
    logic       carry_in = 1'b0;
    logic [7:0] res_data;
    logic       res_carry;
    logic       res_vld;
    logic       res_rdy = 1'b0;
    logic       busy;
    logic       err;

    int total = 0;
    int bad   = 0;
    logic [8:0] q[$];

    sum_collect #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_vld   (bit_vld),
        .bit_in    (bit_in),
        .carry_in  (carry_in),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_vld   (res_vld),
        .res_rdy   (res_rdy),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && res_vld && res_rdy) begin
            if (q.size() == 0) begin
                chk("unexpected_pop", {23'd0, res_carry, res_data}, 32'h1ff);
            end else begin
                logic [8:0] e;
                e = q.pop_front();
                chk("pop_result", {23'd0, res_carry, res_data}, {23'd0, e});
            end
        end
    end

    // Collect one result: start pulse, 8 bits LSB first, optional idle gaps,
    // optional ignored start before bit err_at, then one WRITE-cycle tick.
    task automatic send(input logic [7:0] d, input logic c, input bit gap,
                        input int err_at, input bit lat_chk);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == err_at) begin
                start   = 1'b1;
                bit_vld = 1'b0;
                #1;
                chk("err_pulse", {31'd0, err}, 32'd1);
                tick();
                start = 1'b0;
                #1;
                chk("err_clear", {31'd0, err}, 32'd0);
            end
            bit_vld  = 1'b1;
            bit_in   = d[i];
            carry_in = (i == 7) ? c : 1'b0;
            if (i == 7) q.push_back({c, d});
            tick();
            bit_vld  = 1'b0;
            carry_in = 1'b0;
            if (gap && i < 7) begin
                tick();
                chk("busy_gap", {31'd0, busy}, 32'd1);
            end
        end
        chk("busy_write", {31'd0, busy}, 32'd1);
        if (lat_chk) chk("vld_n1", {31'd0, res_vld}, 32'd0);
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q.size() != 0 || res_vld); i++) tick();
        chk("drain", {31'd0, (q.size() == 0 && !res_vld)}, 32'd1);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_vld",   {31'd0, res_vld},   32'd0);
        chk("rst_data",  {24'd0, res_data},  32'd0);
        chk("rst_carry", {31'd0, res_carry}, 32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_err",   {31'd0, err},       32'd0);
        rst = 1'b0;
        tick();

        // Basic 0x5A with carry, latency check with consumer stalled
        send(8'h5A, 1'b1, 1'b0, -1, 1'b1);
        chk("vld_n2",     {31'd0, res_vld},   32'd1);
        chk("data_5a",    {24'd0, res_data},  32'h5a);
        chk("carry_5a",   {31'd0, res_carry}, 32'd1);
        chk("idle_after", {31'd0, busy},      32'd0);
        res_rdy = 1'b1;
        drain();

        // Same stream with bit_vld low every other cycle
        send(8'h5A, 1'b1, 1'b1, -1, 1'b1);
        drain();

        // Back-pressure: third result held in WRITE
        res_rdy = 1'b0;
        send(8'h01, 1'b0, 1'b0, -1, 1'b0);
        send(8'h02, 1'b1, 1'b0, -1, 1'b0);
        send(8'h03, 1'b0, 1'b0, -1, 1'b0);
        tick();
        tick();
        chk("held_busy", {31'd0, busy},     32'd1);
        chk("held_vld",  {31'd0, res_vld},  32'd1);
        chk("held_head", {24'd0, res_data}, 32'h01);
        // Release: push and pop in the same cycle, buffer stays full
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        chk("pp_busy", {31'd0, busy},     32'd0);
        chk("pp_vld",  {31'd0, res_vld},  32'd1);
        chk("pp_head", {24'd0, res_data}, 32'h02);
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        chk("occ2_vld",  {31'd0, res_vld},  32'd1);
        chk("occ2_head", {24'd0, res_data}, 32'h03);
        // Start in IDLE while the head is being popped
        res_rdy = 1'b1;
        send(8'h3C, 1'b1, 1'b0, -1, 1'b0);
        drain();

        // Ignored start during SHIFT after 3 bits
        send(8'hC3, 1'b0, 1'b0, 3, 1'b0);
        drain();

        // Reset mid-SHIFT discards the partial result
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_vld = 1'b1;
            bit_in  = 1'b1;
            tick();
        end
        bit_vld = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_vld",  {31'd0, res_vld}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy},    32'd0);
        tick();
        send(8'h0F, 1'b0, 1'b0, -1, 1'b1);
        chk("post_rst_data", {24'd0, res_data}, 32'h0f);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
